// File: rtl/eater_pkg.sv
// Shared definitions for the eater machine: bus widths and loader state encoding.
// The CPU controller also uses this package to decide who owns the RAM port.
package eater_pkg;

    localparam int unsigned AW_DEFAULT = 4;
    localparam int unsigned DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        LD_IDLE      = 3'd0,
        LD_WAIT_BYTE = 3'd1,
        LD_WRITE     = 3'd2,
        LD_RD_ISSUE  = 3'd3,
        LD_RD_CHECK  = 3'd4,
        LD_DONE      = 3'd5
    } loader_state_e;

    // The loader owns the RAM port (and halts the CPU) in every state but idle.
    function automatic logic loader_owns_bus(input loader_state_e st);
        return (st != LD_IDLE);
    endfunction

endpackage

// File: rtl/ram_loader.sv
// Program loader: copies 16 host bytes into the RAM while the CPU is halted,
// optionally reading each one back; otherwise passes the CPU's RAM port through.
module ram_loader
    import eater_pkg::*;
#(
    parameter int unsigned AW     = AW_DEFAULT,
    parameter int unsigned DW     = DW_DEFAULT,
    parameter bit          VERIFY = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [AW-1:0] cpu_mar,
    input  logic          cpu_ri,
    input  logic          cpu_ro,
    output logic [AW-1:0] mem_address,
    output logic          ri,
    output logic          ro,
    inout  wire  [DW-1:0] data,
    output logic          cpu_halt,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr
);

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    loader_state_e state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] byte_q, byte_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic          in_ready_q, in_ready_d;
    logic          ri_q, ri_d;
    logic          ro_q, ro_d;
    logic          oe_q, oe_d;
    logic          halt_q, halt_d;
    logic          done_q, done_d;

    // Session sequencing: next state, address counter, latched byte and verify flags.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_d     = byte_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        case (state_q)
            LD_IDLE: begin
                if (start) begin
                    state_d    = LD_WAIT_BYTE;
                    addr_d     = ADDR_ZERO;
                    err_d      = 1'b0;
                    err_addr_d = ADDR_ZERO;
                end else begin
                    state_d = LD_IDLE;
                end
            end
            LD_WAIT_BYTE: begin
                if (in_valid && in_ready_q) begin
                    byte_d  = in_data;
                    state_d = LD_WRITE;
                end else begin
                    state_d = LD_WAIT_BYTE;
                end
            end
            LD_WRITE: begin
                if (VERIFY) begin
                    state_d = LD_RD_ISSUE;
                end else if (addr_q == ADDR_LAST) begin
                    state_d = LD_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = LD_WAIT_BYTE;
                end
            end
            LD_RD_ISSUE: begin
                state_d = LD_RD_CHECK;
            end
            LD_RD_CHECK: begin
                // Only the first mismatch of a session is recorded; the load carries on.
                if ((data != byte_q) && !err_q) begin
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                end else begin
                    err_d      = err_q;
                    err_addr_d = err_addr_q;
                end
                if (addr_q == ADDR_LAST) begin
                    state_d = LD_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = LD_WAIT_BYTE;
                end
            end
            LD_DONE: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // Output strobes are decoded from the next state so they can be registered.
    always_comb begin
        in_ready_d = (state_d == LD_WAIT_BYTE);
        ri_d       = (state_d == LD_WRITE);
        oe_d       = (state_d == LD_WRITE);
        ro_d       = (state_d == LD_RD_ISSUE) || (state_d == LD_RD_CHECK);
        halt_d     = loader_owns_bus(state_d);
        done_d     = (state_d == LD_DONE);
    end

    // State and registered outputs; reset drops every loader strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LD_IDLE;
            addr_q     <= ADDR_ZERO;
            byte_q     <= {DW{1'b0}};
            err_q      <= 1'b0;
            err_addr_q <= ADDR_ZERO;
            in_ready_q <= 1'b0;
            ri_q       <= 1'b0;
            ro_q       <= 1'b0;
            oe_q       <= 1'b0;
            halt_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            in_ready_q <= in_ready_d;
            ri_q       <= ri_d;
            ro_q       <= ro_d;
            oe_q       <= oe_d;
            halt_q     <= halt_d;
            done_q     <= done_d;
        end
    end

    // While the CPU runs, the RAM port is a straight passthrough of its MAR and strobes.
    assign mem_address = halt_q ? addr_q : cpu_mar;
    assign ri          = halt_q ? ri_q   : cpu_ri;
    assign ro          = halt_q ? ro_q   : cpu_ro;
    assign data        = oe_q ? byte_q : {DW{1'bz}};

    assign in_ready = in_ready_q;
    assign cpu_halt = halt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule
